// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for the lab CPU: registered decode, PC stall, mult sequencing,
// data-memory busywait tracking with timeout, and illegal-opcode trapping.
module cpu_control_fsm #(
    parameter int OPCODE_LSB      = 24,
    parameter int MULT_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INSTR_VALID,
    input  logic [31:0] INSTRUCTION,
    input  logic        DMEM_BUSYWAIT,
    output logic [2:0]  ALUOP,
    output logic        MUX_2SCMPL,
    output logic        MUX_IMMD,
    output logic        REG_WRITE_EN,
    output logic        BEQ_EN,
    output logic        BNE_EN,
    output logic        JUMP_EN,
    output logic        SHIFT_EN,
    output logic [1:0]  SHIFTOP,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        MUX_MEMORY,
    output logic        PC_EN,
    output logic        ILLEGAL,
    output logic        TIMEOUT_ERR
);

    localparam int MAX_CNT = (MULT_CYCLES > TIMEOUT_CYCLES) ? MULT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_TRAP} state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       mux_2scmpl;
        logic       mux_immd;
        logic       reg_write;
        logic       beq;
        logic       bne;
        logic       jump;
        logic       shift_en;
        logic [1:0] shiftop;
        logic       mem_read;
        logic       mem_write;
        logic       is_mult;
        logic       illegal;
    } decode_t;

    function automatic decode_t decode_op(input logic [7:0] op);
        decode_t d;
        d = '0;
        case (op)
            8'h00: begin d.mux_immd = 1'b1; d.reg_write = 1'b1; end
            8'h01: d.reg_write = 1'b1;
            8'h02: begin d.aluop = 3'b001; d.reg_write = 1'b1; end
            8'h03: begin d.aluop = 3'b001; d.mux_2scmpl = 1'b1; d.reg_write = 1'b1; end
            8'h04: begin d.aluop = 3'b010; d.reg_write = 1'b1; end
            8'h05: begin d.aluop = 3'b011; d.reg_write = 1'b1; end
            8'h06: begin d.aluop = 3'b111; d.jump = 1'b1; end
            8'h07: begin d.aluop = 3'b001; d.mux_2scmpl = 1'b1; d.beq = 1'b1; end
            8'h08: begin d.mem_read = 1'b1; d.reg_write = 1'b1; end
            8'h09: begin d.mux_immd = 1'b1; d.mem_read = 1'b1; d.reg_write = 1'b1; end
            8'h0A: d.mem_write = 1'b1;
            8'h0B: begin d.mux_immd = 1'b1; d.mem_write = 1'b1; end
            8'h0C: begin d.aluop = 3'b100; d.reg_write = 1'b1; d.is_mult = 1'b1; end
            8'h0D: begin
                d.aluop = 3'b101; d.mux_immd = 1'b1; d.reg_write = 1'b1;
                d.shift_en = 1'b1; d.shiftop = 2'b11;
            end
            8'h0E: begin
                d.aluop = 3'b101; d.mux_immd = 1'b1; d.reg_write = 1'b1;
                d.shift_en = 1'b1; d.shiftop = 2'b00;
            end
            8'h0F: begin
                d.aluop = 3'b110; d.mux_immd = 1'b1; d.reg_write = 1'b1;
                d.shift_en = 1'b1; d.shiftop = 2'b01;
            end
            8'h10: begin
                d.aluop = 3'b110; d.mux_immd = 1'b1; d.reg_write = 1'b1;
                d.shift_en = 1'b1; d.shiftop = 2'b10;
            end
            8'h11: begin d.aluop = 3'b111; d.mux_2scmpl = 1'b1; d.bne = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_t           state_q, state_d;
    decode_t          dec_q, op_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, timeout_q;
    logic             capture, set_illegal, set_timeout, illegal_pulse;
    logic             instr_unused;

    assign op_dec       = decode_op(INSTRUCTION[OPCODE_LSB +: 8]);
    assign instr_unused = ^INSTRUCTION;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;
        illegal_pulse = 1'b0;
        REG_WRITE_EN  = 1'b0;
        PC_EN         = 1'b0;
        BEQ_EN        = 1'b0;
        BNE_EN        = 1'b0;
        JUMP_EN       = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (INSTR_VALID) begin
                    capture = 1'b1;
                    cnt_d   = CNT_ONE;
                    if (op_dec.illegal && TRAP_ON_ILLEGAL) begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end else if (op_dec.mem_read || op_dec.mem_write) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (!dec_q.is_mult || cnt_q == MULT_LAST) begin
                    PC_EN         = 1'b1;
                    REG_WRITE_EN  = dec_q.reg_write;
                    BEQ_EN        = dec_q.beq;
                    BNE_EN        = dec_q.bne;
                    JUMP_EN       = dec_q.jump;
                    illegal_pulse = dec_q.illegal;
                    state_d       = S_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_MEM: begin
                MEM_READ  = dec_q.mem_read;
                MEM_WRITE = dec_q.mem_write;
                // The first MEM cycle never completes; completion wins over timeout.
                if (!DMEM_BUSYWAIT && cnt_q != CNT_ONE) begin
                    PC_EN        = 1'b1;
                    REG_WRITE_EN = dec_q.reg_write;
                    state_d      = S_IDLE;
                    cnt_d        = '0;
                end else if (DMEM_BUSYWAIT && cnt_q == TMO_LAST) begin
                    state_d     = S_TRAP;
                    set_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_TRAP: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            dec_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture)     dec_q     <= op_dec;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    assign ALUOP       = dec_q.aluop;
    assign MUX_2SCMPL  = dec_q.mux_2scmpl;
    assign MUX_IMMD    = dec_q.mux_immd;
    assign SHIFT_EN    = dec_q.shift_en;
    assign SHIFTOP     = dec_q.shiftop;
    assign MUX_MEMORY  = dec_q.mem_read;
    assign ILLEGAL     = illegal_q | illegal_pulse;
    assign TIMEOUT_ERR = timeout_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: two instances (trap/timeout 4 and NOP-illegal/timeout 8)
// share stimulus; each cycle's expected outputs are queued by the driver and popped by a monitor.
module tb_cpu_control_fsm;

    typedef logic [17:0] outv_t;  // {aluop,2scmpl,immd,shift_en,shiftop,mux_mem, rwe,beq,bne,jmp,mrd,mwr,pc,ill,tmo}

    typedef struct {
        outv_t ea;
        outv_t eb;
        string tag;
    } exp_t;

    localparam logic [7:0] OP_ADD = 8'h02, OP_SUB = 8'h03, OP_BEQ = 8'h07, OP_JMP = 8'h06;
    localparam logic [7:0] OP_BNE = 8'h11, OP_SRA = 8'h0D, OP_SRL = 8'h0F, OP_MULT = 8'h0C;
    localparam logic [7:0] OP_LWD = 8'h08, OP_SWI = 8'h0B, OP_ILL = 8'h20;

    localparam outv_t Z      = 18'h0;
    localparam outv_t D_ADD  = {3'b001, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_SUB  = {3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_BEQ  = {3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_JMP  = {3'b111, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_BNE  = {3'b111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_SRA  = {3'b101, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 9'b0};
    localparam outv_t D_SRL  = {3'b110, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 9'b0};
    localparam outv_t D_MULT = {3'b100, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 9'b0};
    localparam outv_t D_LWD  = {3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 9'b0};
    localparam outv_t D_SWI  = {3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 9'b0};

    localparam outv_t E_RWE = 18'h100, E_BEQ = 18'h080, E_BNE = 18'h040, E_JMP = 18'h020;
    localparam outv_t E_MRD = 18'h010, E_MWR = 18'h008, E_PC  = 18'h004, E_ILL = 18'h002;
    localparam outv_t E_TMO = 18'h001;

    logic        CLK, RESET, INSTR_VALID, DMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;

    logic [2:0] aluop_a, aluop_b;
    logic [1:0] shop_a, shop_b;
    logic m2s_a, mimm_a, rwe_a, beq_a, bne_a, jmp_a, shen_a, mrd_a, mwr_a, mmem_a, pc_a, ill_a, tmo_a;
    logic m2s_b, mimm_b, rwe_b, beq_b, bne_b, jmp_b, shen_b, mrd_b, mwr_b, mmem_b, pc_b, ill_b, tmo_b;

    cpu_control_fsm #(.OPCODE_LSB(24), .MULT_CYCLES(3), .TIMEOUT_CYCLES(4), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .ALUOP(aluop_a), .MUX_2SCMPL(m2s_a), .MUX_IMMD(mimm_a),
        .REG_WRITE_EN(rwe_a), .BEQ_EN(beq_a), .BNE_EN(bne_a), .JUMP_EN(jmp_a), .SHIFT_EN(shen_a),
        .SHIFTOP(shop_a), .MEM_READ(mrd_a), .MEM_WRITE(mwr_a), .MUX_MEMORY(mmem_a), .PC_EN(pc_a),
        .ILLEGAL(ill_a), .TIMEOUT_ERR(tmo_a)
    );

    cpu_control_fsm #(.OPCODE_LSB(24), .MULT_CYCLES(3), .TIMEOUT_CYCLES(8), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .ALUOP(aluop_b), .MUX_2SCMPL(m2s_b), .MUX_IMMD(mimm_b),
        .REG_WRITE_EN(rwe_b), .BEQ_EN(beq_b), .BNE_EN(bne_b), .JUMP_EN(jmp_b), .SHIFT_EN(shen_b),
        .SHIFTOP(shop_b), .MEM_READ(mrd_b), .MEM_WRITE(mwr_b), .MUX_MEMORY(mmem_b), .PC_EN(pc_b),
        .ILLEGAL(ill_b), .TIMEOUT_ERR(tmo_b)
    );

    outv_t act_a, act_b;
    assign act_a = {aluop_a, m2s_a, mimm_a, shen_a, shop_a, mmem_a,
                    rwe_a, beq_a, bne_a, jmp_a, mrd_a, mwr_a, pc_a, ill_a, tmo_a};
    assign act_b = {aluop_b, m2s_b, mimm_b, shen_b, shop_b, mmem_b,
                    rwe_b, beq_b, bne_b, jmp_b, mrd_b, mwr_b, pc_b, ill_b, tmo_b};

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if (act_a !== cur.ea) begin
                errors++;
                $display("FAIL %s dut_a: got %05h expected %05h", cur.tag, act_a, cur.ea);
            end
            checks++;
            if (act_b !== cur.eb) begin
                errors++;
                $display("FAIL %s dut_b: got %05h expected %05h", cur.tag, act_b, cur.eb);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] op, input logic busy, input logic rn,
                        input outv_t ea, input outv_t eb, input string tag);
        exp_t ent;
        @(posedge CLK);
        #1;
        INSTR_VALID   = v;
        INSTRUCTION   = {op, 24'h5A3C96};
        DMEM_BUSYWAIT = busy;
        RESET         = rn;
        ent.ea  = ea;
        ent.eb  = eb;
        ent.tag = tag;
        sb.push_back(ent);
    endtask

    task automatic step1(input logic v, input logic [7:0] op, input logic busy, input logic rn,
                         input outv_t e, input string tag);
        step(v, op, busy, rn, e, e, tag);
    endtask

    // Capture cycle shows the previous decode; the EXEC cycle offers a stray mult that must be ignored.
    task automatic single(input logic [7:0] op, input outv_t dprev, input outv_t dnew,
                          input outv_t en, input string tag);
        step1(1'b1, op, 1'b0, 1'b1, dprev, tag);
        step1(1'b1, OP_MULT, 1'b0, 1'b1, dnew | en, tag);
    endtask

    initial begin
        RESET = 1'b1; INSTR_VALID = 1'b0; INSTRUCTION = '0; DMEM_BUSYWAIT = 1'b0;
        #2 RESET = 1'b0;

        step1(1'b0, 8'h00, 1'b0, 1'b0, Z, "reset_hold");
        step1(1'b1, OP_ADD, 1'b1, 1'b0, Z, "reset_ignores_inputs");
        step1(1'b0, 8'h00, 1'b0, 1'b1, Z, "reset_release");

        single(OP_ADD, Z,     D_ADD, E_RWE | E_PC, "add");
        single(OP_SUB, D_ADD, D_SUB, E_RWE | E_PC, "sub");
        single(OP_BEQ, D_SUB, D_BEQ, E_BEQ | E_PC, "beq");
        single(OP_JMP, D_BEQ, D_JMP, E_JMP | E_PC, "jump");
        single(OP_BNE, D_JMP, D_BNE, E_BNE | E_PC, "bne");
        single(OP_SRA, D_BNE, D_SRA, E_RWE | E_PC, "sra");
        single(OP_SRL, D_SRA, D_SRL, E_RWE | E_PC, "srl");

        step1(1'b1, OP_MULT, 1'b0, 1'b1, D_SRL, "mult_capture");
        step1(1'b1, OP_ADD, 1'b0, 1'b1, D_MULT, "mult_exec1");
        step1(1'b1, OP_ADD, 1'b0, 1'b1, D_MULT, "mult_exec2");
        step1(1'b0, OP_ADD, 1'b0, 1'b1, D_MULT | E_RWE | E_PC, "mult_exec3");
        step1(1'b0, OP_ADD, 1'b0, 1'b1, D_MULT, "mult_idle");

        step1(1'b1, OP_LWD, 1'b1, 1'b1, D_MULT, "lwd_capture");
        for (int i = 0; i < 4; i++) step1(1'b1, OP_ADD, 1'b1, 1'b1, D_LWD | E_MRD, "lwd_wait");
        step(1'b1, OP_ADD, 1'b1, 1'b1, D_LWD | E_TMO, D_LWD | E_MRD, "lwd_wait5");
        step(1'b0, OP_ADD, 1'b0, 1'b1, D_LWD | E_TMO, D_LWD | E_MRD | E_RWE | E_PC, "lwd_done");
        step(1'b0, OP_ADD, 1'b0, 1'b1, D_LWD | E_TMO, D_LWD, "lwd_idle");
        step1(1'b0, 8'h00, 1'b0, 1'b0, Z, "rst_after_lwd");
        step1(1'b0, 8'h00, 1'b0, 1'b1, Z, "rel_after_lwd");

        step1(1'b1, OP_SWI, 1'b1, 1'b1, Z, "swi_capture");
        for (int i = 0; i < 4; i++) step1(1'b0, 8'h00, 1'b1, 1'b1, D_SWI | E_MWR, "swi_wait");
        for (int i = 0; i < 4; i++) step(1'b1, OP_ADD, 1'b1, 1'b1, D_SWI | E_TMO, D_SWI | E_MWR, "swi_trap");
        step1(1'b1, OP_ADD, 1'b1, 1'b1, D_SWI | E_TMO, "swi_trap_both");
        step1(1'b1, OP_ADD, 1'b0, 1'b1, D_SWI | E_TMO, "trap_sticky");
        step1(1'b0, 8'h00, 1'b0, 1'b0, Z, "rst_after_swi");
        step1(1'b0, 8'h00, 1'b0, 1'b1, Z, "rel_after_swi");

        step1(1'b1, OP_LWD, 1'b1, 1'b1, Z, "edge_capture");
        for (int i = 0; i < 3; i++) step1(1'b0, 8'h00, 1'b1, 1'b1, D_LWD | E_MRD, "edge_wait");
        step1(1'b0, 8'h00, 1'b0, 1'b1, D_LWD | E_MRD | E_RWE | E_PC, "edge_done_at_timeout");
        step1(1'b1, OP_SWI, 1'b0, 1'b1, D_LWD, "first_capture");
        step1(1'b0, 8'h00, 1'b0, 1'b1, D_SWI | E_MWR, "first_cycle_no_complete");
        step1(1'b0, 8'h00, 1'b0, 1'b1, D_SWI | E_MWR | E_PC, "first_done");

        step1(1'b1, OP_ILL, 1'b0, 1'b1, D_SWI, "ill_capture");
        step(1'b0, 8'h00, 1'b0, 1'b1, E_ILL, E_PC | E_ILL, "ill_exec");
        step(1'b1, OP_ADD, 1'b0, 1'b1, E_ILL, Z, "ill_after");
        step(1'b0, 8'h00, 1'b0, 1'b1, E_ILL, D_ADD | E_RWE | E_PC, "ill_add");
        step(1'b0, 8'h00, 1'b0, 1'b1, E_ILL, D_ADD, "ill_idle");
        step1(1'b0, 8'h00, 1'b0, 1'b0, Z, "rst_after_ill");
        step1(1'b0, 8'h00, 1'b0, 1'b1, Z, "rel_after_ill");

        step1(1'b1, OP_LWD, 1'b1, 1'b1, Z, "rm_capture");
        step1(1'b0, 8'h00, 1'b1, 1'b1, D_LWD | E_MRD, "rm_mem1");
        step1(1'b0, 8'h00, 1'b1, 1'b0, Z, "rm_async_reset");
        step1(1'b0, 8'h00, 1'b1, 1'b1, Z, "rm_release");
        single(OP_ADD, Z, D_ADD, E_RWE | E_PC, "rm_add");
        step1(1'b0, 8'h00, 1'b0, 1'b1, D_ADD, "rm_idle");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Registered multi-cycle successor to the combinational decoder of the lab CPU. It sits between the instruction fetch path, the register file/ALU datapath and the data memory. It replaces per-instruction combinational decode and ad-hoc busywait handling with a single state machine. The state machine does four things: stalls the PC while fetches are pending, sequences multi-cycle multiply, tracks data-memory busywait with a timeout, and traps on illegal opcodes.

## Interface
Parameters:
- OPCODE_LSB, 24: bit position of the opcode LSB within INSTRUCTION. The opcode is INSTRUCTION[OPCODE_LSB+7:OPCODE_LSB].
- MULT_CYCLES, 2: total execute cycles for mult (opcode 0x0C). Must be ≥1.
- TIMEOUT_CYCLES, 64: maximum number of MEM-state cycles before the timeout trap fires. Must be ≥2.
- TRAP_ON_ILLEGAL, 1: 1 = an illegal opcode enters TRAP; 0 = an illegal opcode retires as a NOP.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle (instruction fetch not busy).
- INSTRUCTION  in  32  fetched instruction word.
- DMEM_BUSYWAIT  in  1  data memory busy.
- ALUOP  out  3  ALU function select.
- MUX_2SCMPL, MUX_IMMD  out  1 each  datapath operand selects.
- REG_WRITE_EN  out  1  register file write enable.
- BEQ_EN, BNE_EN, JUMP_EN  out  1 each  branch/jump qualifiers; asserted only in the retiring cycle.
- SHIFT_EN  out  1  shifter result select.
- SHIFTOP  out  2  shift type.
- MEM_READ, MEM_WRITE  out  1 each  data memory request.
- MUX_MEMORY  out  1  write-back source select (1 = memory data).
- PC_EN  out  1  one-cycle pulse per retired instruction; the PC advances only on this pulse.
- ILLEGAL, TIMEOUT_ERR  out  1 each  trap cause flags.

## Operation
- Opcode decode (hex), registered into a decode register on instruction capture:
  - ALUOP by opcode:
    - 000: 00, 01, 08, 09, 0A, 0B
    - 001: 02, 03, 07
    - 010: 04
    - 011: 05
    - 100: 0C
    - 101: 0D, 0E
    - 110: 0F, 10
    - 111: 06, 11
  - MUX_IMMD=1: 00, 0D, 0E, 0F, 10, 09, 0B.
  - MUX_2SCMPL=1: 03, 07, 11.
  - Write-back opcodes (REG_WRITE_EN asserted when the instruction completes): 00–05, 0C–10, 08, 09.
  - SHIFT_EN=1: 0D–10. SHIFTOP: 0D=11, 0E=00, 0F=01, 10=10. SHIFTOP is 00 otherwise and is never X.
  - Branch/jump: BEQ 07, JUMP 06, BNE 11.
  - Loads 08/09: MEM_READ and MUX_MEMORY.
  - Stores 0A/0B: MEM_WRITE.
  - Opcodes ≥ 0x12 are illegal.
- States and transitions:
  - IDLE: waits for INSTR_VALID. Captures the decode register on an edge where INSTR_VALID=1. Then goes to TRAP (illegal and TRAP_ON_ILLEGAL=1), MEM (load/store), or EXEC (everything else).
  - EXEC: holds for MULT_CYCLES cycles if the opcode is 0x0C, otherwise 1 cycle. A cycle counter runs for mult. In the final cycle, PC_EN=1, REG_WRITE_EN and the branch/jump enable per decode are asserted, then the FSM returns to IDLE. Earlier mult cycles have all enables 0.
  - MEM: MEM_READ/MEM_WRITE are held from entry until completion. Completion is the first edge, after at least one full MEM cycle, at which DMEM_BUSYWAIT=0. In the completing cycle (combinationally on DMEM_BUSYWAIT=0 with the first-cycle flag clear), REG_WRITE_EN (loads only) and PC_EN are asserted; the next state is IDLE. If the counter reaches TIMEOUT_CYCLES with DMEM_BUSYWAIT still 1, the FSM goes to TRAP and sets TIMEOUT_ERR.
  - TRAP: all enables and requests are 0. ILLEGAL/TIMEOUT_ERR are sticky. Only RESET exits TRAP.
- Illegal opcode with TRAP_ON_ILLEGAL=0: goes to EXEC for 1 cycle with PC_EN=1, all other enables 0, and ILLEGAL pulsed for that cycle only.
- Outside their asserting state: REG_WRITE_EN, PC_EN, BEQ_EN, BNE_EN, JUMP_EN, MEM_READ and MEM_WRITE are 0. ALUOP, the muxes and SHIFTOP hold the decode register.

## Timing
- RESET low, at any time including mid-MEM or mid-mult:
  - State goes to IDLE immediately.
  - All outputs are 0 (ALUOP=000, SHIFTOP=00).
  - Counters, decode register and trap flags are cleared.
  - An in-flight memory request is dropped.
- Latency: single-cycle ops take 2 cycles (IDLE capture + EXEC). mult takes 1+MULT_CYCLES cycles. Loads/stores take 1 + N cycles, where N is the MEM cycles up to and including the first busywait-low cycle.
- INSTR_VALID is ignored outside IDLE. INSTRUCTION may change freely after capture.
- DMEM_BUSYWAIT is ignored outside MEM.
- The timeout counter counts MEM cycles from 1. A busywait falling exactly in cycle TIMEOUT_CYCLES completes normally: completion has priority over timeout.

## Test plan
- Reset, then add (0x02) with INSTR_VALID=1: EXEC next cycle with ALUOP=001, REG_WRITE_EN=1, PC_EN=1 for exactly 1 cycle, then IDLE.
- mult (0x0C), MULT_CYCLES=3: REG_WRITE_EN and PC_EN are 0 for 2 cycles, then 1 in the 3rd EXEC cycle only.
- lwd (0x08), busywait high for 5 cycles: MEM_READ=1 throughout, MUX_MEMORY=1; REG_WRITE_EN and PC_EN pulse once in the busywait-low cycle.
- swi (0x0B), TIMEOUT_CYCLES=4, busywait stuck high: TRAP after 4 MEM cycles, TIMEOUT_ERR=1 sticky, MEM_WRITE=0, later INSTR_VALID ignored.
- Opcode 0x20: with TRAP_ON_ILLEGAL=1, ILLEGAL stays 1 and PC_EN is never asserted. With TRAP_ON_ILLEGAL=0, ILLEGAL and PC_EN pulse together once with no writes.
- RESET asserted in the 2nd MEM cycle of a load: all outputs 0 at once; after release, an add retires normally.
